// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT output reorder buffer.
package fft_pkg;
  localparam int LOG2N = 7;
  localparam int N     = 1 << LOG2N;
  localparam int DW    = 32;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
  typedef enum logic {W_IDLE, W_FILL}  wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;
endpackage

// File: rtl/fft_reorder_buffer_if.sv
// Input sample stream and natural-order output stream of the reorder buffer.
interface fft_reorder_buffer_if #(
  parameter int DW    = fft_pkg::DW,
  parameter int LOG2N = fft_pkg::LOG2N
);
  logic             in_valid;
  logic             in_sof;
  logic [LOG2N-1:0] in_addr;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic [DW-1:0]    out_data;
  logic             frame_err;

  modport slave (
    input  in_valid, in_sof, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_sof, out_eof, out_data, frame_err
  );

  modport master (
    output in_valid, in_sof, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_sof, out_eof, out_data, frame_err
  );
endinterface

// File: rtl/fft_reorder_buffer_bank.sv
// One frame of sample storage: synchronous write, asynchronous read.
module reorder_bank #(
  parameter int DW    = fft_pkg::DW,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [DW-1:0]    rdata
);
  logic [DW-1:0] mem [1 << LOG2N];

  // Storage is not reset; unwritten entries simply keep old samples.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: fills one bank at bit-reversed addresses while
// the other bank drains in natural order onto a valid/ready stream.
module fft_reorder_buffer #(
  parameter int DW    = fft_pkg::DW,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic               clk,
  input  logic               rst,
  fft_reorder_buffer_if.slave bus
);
  import fft_pkg::*;

  localparam int FRAME = 1 << LOG2N;
  localparam logic [LOG2N:0] CNT_ONE  = (LOG2N+1)'(1);
  localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(FRAME - 1);
  localparam logic [LOG2N:0] CNT_END  = (LOG2N+1)'(FRAME);

  bank_state_e bst [2];
  logic        wr_bank, rd_bank;
  wr_state_e   wst, wst_nx;
  rd_state_e   rst_q, rst_nx;
  logic [LOG2N:0] wr_cnt, rd_addr;

  logic acc, wr_en, fill_start, fill_done, abort;
  logic drain_start, drain_done, load, out_acc;
  logic [1:0]         we;
  logic [1:0][DW-1:0] rdata;

  assign bus.in_ready = (bst[wr_bank] == EMPTY) || (bst[wr_bank] == FILLING);
  assign acc     = bus.in_valid && bus.in_ready;
  assign out_acc = bus.out_valid && bus.out_ready;
  // Idle drops samples until a frame start shows up.
  assign wr_en   = acc && (wst == W_FILL || bus.in_sof);
  assign we      = {wr_en && wr_bank, wr_en && !wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(.DW(DW), .LOG2N(LOG2N)) u_bank (
      .clk   (clk),
      .we    (we[b]),
      .waddr (bus.in_addr),
      .wdata (bus.in_data),
      .raddr (rd_addr[LOG2N-1:0]),
      .rdata (rdata[b])
    );
  end

  // FSM state registers.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wst   <= W_IDLE;
      rst_q <= R_IDLE;
    end else begin
      wst   <= wst_nx;
      rst_q <= rst_nx;
    end

  // Write FSM: frame start, mid-frame restart, frame completion.
  always_comb begin
    wst_nx     = wst;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    abort      = 1'b0;
    case (wst)
      W_IDLE:
        if (acc && bus.in_sof) begin
          fill_start = 1'b1;
          wst_nx     = W_FILL;
        end
      W_FILL:
        if (acc) begin
          if (bus.in_sof) begin
            abort      = 1'b1;
            fill_start = 1'b1;
          end else if (wr_cnt == CNT_LAST) begin
            fill_done = 1'b1;
            wst_nx    = W_IDLE;
          end
        end
      default: wst_nx = W_IDLE;
    endcase
  end

  // Read FSM: claim a full bank, stream it out, release after the last sample.
  always_comb begin
    rst_nx      = rst_q;
    drain_start = 1'b0;
    drain_done  = 1'b0;
    load        = 1'b0;
    case (rst_q)
      R_IDLE:
        if (bst[rd_bank] == FULL) begin
          drain_start = 1'b1;
          rst_nx      = R_DRAIN;
        end
      R_DRAIN: begin
        load = (!bus.out_valid || bus.out_ready) && (rd_addr != CNT_END);
        if (out_acc && bus.out_eof) begin
          drain_done = 1'b1;
          rst_nx     = R_IDLE;
        end
      end
      default: rst_nx = R_IDLE;
    endcase
  end

  // Bank states, pointers, counters and the abort pulse. Write and read
  // sides never touch the same bank in one cycle, so both updates apply.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bst[0]        <= EMPTY;
      bst[1]        <= EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_addr       <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      if (fill_start) begin
        wr_cnt       <= CNT_ONE;
        bst[wr_bank] <= FILLING;
      end else if (acc && wst == W_FILL) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (fill_done) begin
        bst[wr_bank] <= FULL;
        wr_bank      <= ~wr_bank;
        wr_cnt       <= '0;
      end
      if (drain_start) begin
        bst[rd_bank] <= DRAINING;
        rd_addr      <= '0;
      end
      if (load) rd_addr <= rd_addr + 1'b1;
      if (drain_done) begin
        bst[rd_bank] <= EMPTY;
        rd_bank      <= ~rd_bank;
      end
      bus.frame_err <= abort;
    end

  // Output register: load when empty or being consumed, hold while stalled.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_data  <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_sof   <= (rd_addr == '0);
      bus.out_eof   <= (rd_addr == CNT_LAST);
      bus.out_data  <= rdata[rd_bank];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
endmodule
